// File: rtl/anc_delay_sum.sv
// rtl/anc_delay_sum.sv - programmable anti-noise delay line with saturating sum into the detector path
//
// Purpose:
//   Delays the inverted-noise sample (anti_in) by delay_reg samples through a
//   circular buffer. Each delayed sample is added to the detector sample (sig_in)
//   with signed saturation. The cancelled result is registered together with a
//   one-cycle valid strobe.
//
// Ports:
//   clk        rising-edge system clock
//   rst        synchronous active-high reset
//   in_valid   sig_in / anti_in pair accepted this cycle
//   sig_in     signed detector sample
//   anti_in    signed anti-noise sample
//   cfg_load   load delay_cfg into delay_reg and flush the fill count
//   delay_cfg  requested delay in samples (0..MAX_DELAY-1)
//   out_data   signed saturated sum (held while out_valid=0)
//   out_valid  one-cycle strobe per accepted sample
//   sat_flag   out_data of the last strobe was clipped (held while out_valid=0)
//   primed     fill count covers the current delay

module anc_delay_sum #(
    parameter int DATA_W    = 16,
    parameter int MAX_DELAY = 64,
    parameter int DLY_W     = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] sig_in,
    input  logic signed [DATA_W-1:0] anti_in,
    input  logic                     cfg_load,
    input  logic        [DLY_W-1:0]  delay_cfg,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic                     sat_flag,
    output logic                     primed
);

    // fill counts 0..MAX_DELAY inclusive, so it needs one bit more than the pointer
    localparam int FILL_W = DLY_W + 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_DELAY);

    localparam logic signed [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Sample storage is never cleared; stale entries are masked by fill.
    logic signed [DATA_W-1:0] sample_buf [MAX_DELAY];

    logic [DLY_W-1:0]  wr_ptr;
    logic [DLY_W-1:0]  delay_reg;
    logic [FILL_W-1:0] fill;

    // Effective configuration for this edge: a cfg_load takes effect on the
    // sample accepted in the same cycle, which therefore sees an empty history.
    logic [DLY_W-1:0]  eff_delay;
    logic [FILL_W-1:0] eff_fill;
    logic [FILL_W-1:0] fill_next;
    logic [DLY_W-1:0]  rd_ptr;

    logic signed [DATA_W-1:0] delayed;
    logic signed [DATA_W:0]   sum;
    logic signed [DATA_W-1:0] sum_sat;
    logic                     sum_ovf;

    always_comb begin
        eff_delay = cfg_load ? delay_cfg : delay_reg;
        eff_fill  = cfg_load ? '0 : fill;

        // Pointer arithmetic wraps naturally because MAX_DELAY is 2**DLY_W.
        rd_ptr = wr_ptr - eff_delay;

        // Read happens before this edge's write, so buf[rd_ptr] is the sample
        // accepted exactly eff_delay samples ago.
        if (eff_delay == '0) begin
            delayed = anti_in;
        end else if (eff_fill >= {1'b0, eff_delay}) begin
            delayed = sample_buf[rd_ptr];
        end else begin
            delayed = '0;
        end

        sum = {sig_in[DATA_W-1], sig_in} + {delayed[DATA_W-1], delayed};

        // The result overflows DATA_W exactly when the two top bits of the
        // widened sum disagree; the top bit then tells the direction.
        sum_ovf = sum[DATA_W] ^ sum[DATA_W-1];
        if (!sum_ovf) begin
            sum_sat = sum[DATA_W-1:0];
        end else if (sum[DATA_W]) begin
            sum_sat = NEG_MIN;
        end else begin
            sum_sat = POS_MAX;
        end

        if (in_valid && (eff_fill != FILL_MAX)) begin
            fill_next = eff_fill + FILL_W'(1);
        end else begin
            fill_next = eff_fill;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            fill      <= '0;
            delay_reg <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
            primed    <= 1'b0;
        end else begin
            delay_reg <= eff_delay;
            fill      <= fill_next;
            primed    <= (fill_next >= {1'b0, eff_delay});
            out_valid <= in_valid;
            if (in_valid) begin
                wr_ptr   <= wr_ptr + DLY_W'(1);
                out_data <= sum_sat;
                sat_flag <= sum_ovf;
            end
        end
    end

    // Storage has no reset; a sample presented during reset is discarded.
    always_ff @(posedge clk) begin
        if (!rst && in_valid) begin
            sample_buf[wr_ptr] <= anti_in;
        end
    end

endmodule

// File: tb/tb_anc_delay_sum.sv
// tb/tb_anc_delay_sum.sv - self-checking bench for anc_delay_sum against a queue-based reference

module tb_anc_delay_sum;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [15:0] sig_in;
    logic signed [15:0] anti_in;
    logic               cfg_load;
    logic        [5:0]  delay_cfg;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               sat_flag;
    logic               primed;

    int tests_run = 0;
    int failures  = 0;

    // Reference: history of anti samples since the last flush, newest last.
    logic signed [15:0] hist [$];
    int                 m_delay;
    logic signed [15:0] m_out;
    logic               m_valid;
    logic               m_sat;
    logic               m_primed;

    always #5 clk = ~clk;

    anc_delay_sum #(.DATA_W(16), .MAX_DELAY(64), .DLY_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .sig_in    (sig_in),
        .anti_in   (anti_in),
        .cfg_load  (cfg_load),
        .delay_cfg (delay_cfg),
        .out_data  (out_data),
        .out_valid (out_valid),
        .sat_flag  (sat_flag),
        .primed    (primed)
    );

    // Applies one cycle of stimulus and advances the reference model.
    task automatic drive(input logic v, input logic signed [15:0] s, input logic signed [15:0] a,
                         input logic ld, input logic [5:0] cfg, input logic r);
        int n;
        int sum;
        logic signed [15:0] del;
        in_valid  = v;
        sig_in    = s;
        anti_in   = a;
        cfg_load  = ld;
        delay_cfg = cfg;
        rst       = r;
        @(posedge clk);
        if (r) begin
            hist.delete();
            m_delay  = 0;
            m_out    = 0;
            m_sat    = 0;
            m_valid  = 0;
            m_primed = 0;
        end else begin
            if (ld) begin
                m_delay = int'(cfg);
                hist.delete();
            end
            if (v) begin
                n = hist.size();
                if (m_delay == 0)      del = a;
                else if (n >= m_delay) del = hist[n - m_delay];
                else                   del = 0;
                sum = int'(s) + int'(del);
                if (sum > 32767) begin
                    m_out = 16'sd32767; m_sat = 1;
                end else if (sum < -32768) begin
                    m_out = -16'sd32768; m_sat = 1;
                end else begin
                    m_out = 16'(sum); m_sat = 0;
                end
                hist.push_back(a);
                if (hist.size() > 64) void'(hist.pop_front());
            end
            m_valid  = v;
            m_primed = (hist.size() >= m_delay);
        end
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        tests_run++;
        if ({out_valid, out_data, sat_flag, primed} !== 19'd0) begin
            failures++;
            $display("FAIL reset: got v=%0b d=%0d s=%0b p=%0b want all 0", out_valid, out_data, sat_flag, primed);
        end
    endtask

    task automatic test_passthrough();
        drive(1, 16'sd1000, -16'sd400, 0, 0, 0);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 16'sd600 || sat_flag !== 1'b0 || primed !== 1'b1) begin
            failures++;
            $display("FAIL passthrough: got v=%0b d=%0d s=%0b p=%0b want v=1 d=600 s=0 p=1",
                     out_valid, out_data, sat_flag, primed);
        end
        drive(0, 0, 0, 0, 0, 0);
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 16'sd600 || sat_flag !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: got v=%0b d=%0d s=%0b want v=0 d=600 s=0", out_valid, out_data, sat_flag);
        end
    endtask

    task automatic test_delay3();
        logic signed [15:0] exp_out [5] = '{16'sd0, 16'sd0, 16'sd0, 16'sd10, 16'sd20};
        logic               exp_pr  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        drive(0, 0, 0, 1, 6'd3, 0);
        tests_run++;
        if (primed !== 1'b0) begin
            failures++;
            $display("FAIL delay3_load_primed: got %0b want 0", primed);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 16'(10 * (i + 1)), 0, 0, 0);
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== exp_out[i] || primed !== exp_pr[i]) begin
                failures++;
                $display("FAIL delay3[%0d]: got v=%0b d=%0d p=%0b want v=1 d=%0d p=%0b",
                         i, out_valid, out_data, primed, exp_out[i], exp_pr[i]);
            end
        end
    endtask

    task automatic test_saturation();
        drive(1, 16'sd30000, 16'sd5000, 1, 6'd0, 0);
        tests_run++;
        if (out_data !== 16'sd32767 || sat_flag !== 1'b1) begin
            failures++;
            $display("FAIL sat_pos: got d=%0d s=%0b want d=32767 s=1", out_data, sat_flag);
        end
        drive(1, -16'sd30000, -16'sd5000, 0, 0, 0);
        tests_run++;
        if (out_data !== -16'sd32768 || sat_flag !== 1'b1) begin
            failures++;
            $display("FAIL sat_neg: got d=%0d s=%0b want d=-32768 s=1", out_data, sat_flag);
        end
        drive(0, 0, 0, 0, 0, 0);
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== -16'sd32768 || sat_flag !== 1'b1) begin
            failures++;
            $display("FAIL sat_hold: got v=%0b d=%0d s=%0b want v=0 d=-32768 s=1", out_valid, out_data, sat_flag);
        end
        drive(1, 16'sd32767, -16'sd1, 0, 0, 0);
        tests_run++;
        if (out_data !== 16'sd32766 || sat_flag !== 1'b0) begin
            failures++;
            $display("FAIL sat_edge: got d=%0d s=%0b want d=32766 s=0", out_data, sat_flag);
        end
    endtask

    task automatic test_wrap();
        logic signed [15:0] exp;
        drive(0, 0, 0, 1, 6'd63, 0);
        for (int n = 0; n < 200; n++) begin
            drive(1, 0, 16'(n), 0, 0, 0);
            exp = (n >= 63) ? 16'(n - 63) : 16'sd0;
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== exp || out_data !== m_out || primed !== m_primed) begin
                failures++;
                $display("FAIL wrap[%0d]: got v=%0b d=%0d p=%0b want v=1 d=%0d p=%0b",
                         n, out_valid, out_data, primed, exp, m_primed);
            end
        end
    endtask

    task automatic test_reconfig();
        logic signed [15:0] s;
        drive(0, 0, 0, 1, 6'd2, 0);
        for (int i = 0; i < 6; i++) drive(1, 16'($urandom_range(2000)), 16'($urandom_range(2000)), 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            s = 16'($urandom_range(2000));
            drive(1, s, 16'($urandom_range(2000)), (i == 0), 6'd5, 0);
            tests_run++;
            if (out_valid !== m_valid || out_data !== m_out || sat_flag !== m_sat || primed !== m_primed
                || (i < 5 && out_data !== s)) begin
                failures++;
                $display("FAIL reconfig[%0d]: got v=%0b d=%0d s=%0b p=%0b want v=%0b d=%0d s=%0b p=%0b",
                         i, out_valid, out_data, sat_flag, primed, m_valid, m_out, m_sat, m_primed);
            end
        end
    endtask

    task automatic test_midreset();
        logic signed [15:0] s;
        drive(0, 0, 0, 1, 6'd2, 0);
        for (int i = 0; i < 5; i++) drive(1, 16'sd100, 16'(i + 7), 0, 0, 0);
        drive(1, 16'sd500, 16'sd500, 0, 0, 1);
        tests_run++;
        if ({out_valid, out_data, sat_flag, primed} !== 19'd0) begin
            failures++;
            $display("FAIL midreset: got v=%0b d=%0d s=%0b p=%0b want all 0", out_valid, out_data, sat_flag, primed);
        end
        for (int i = 0; i < 4; i++) begin
            s = 16'($urandom_range(1000));
            drive(1, s, 16'sd77, (i == 0), 6'd3, 0);
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== m_out || primed !== m_primed || (i < 3 && out_data !== s)) begin
                failures++;
                $display("FAIL midreset_post[%0d]: got v=%0b d=%0d p=%0b want v=1 d=%0d p=%0b",
                         i, out_valid, out_data, primed, m_out, m_primed);
            end
        end
    endtask

    task automatic test_random();
        logic               v, ld, r;
        logic signed [15:0] s, a;
        for (int i = 0; i < 3000; i++) begin
            v  = ($urandom_range(3) != 0);
            ld = ($urandom_range(99) < 2);
            r  = ($urandom_range(999) < 3);
            s  = ($urandom_range(1)) ? 16'($urandom) : 16'(int'($urandom_range(2000)) - 1000);
            a  = ($urandom_range(1)) ? 16'($urandom) : 16'(int'($urandom_range(2000)) - 1000);
            drive(v, s, a, ld, 6'($urandom_range(63)), r);
            tests_run++;
            if (out_valid !== m_valid || out_data !== m_out || sat_flag !== m_sat || primed !== m_primed) begin
                failures++;
                $display("FAIL random[%0d]: got v=%0b d=%0d s=%0b p=%0b want v=%0b d=%0d s=%0b p=%0b",
                         i, out_valid, out_data, sat_flag, primed, m_valid, m_out, m_sat, m_primed);
            end
        end
    endtask

    initial begin
        rst = 1; in_valid = 0; sig_in = 0; anti_in = 0; cfg_load = 0; delay_cfg = 0;
        m_delay = 0; m_out = 0; m_sat = 0; m_valid = 0; m_primed = 0;
        test_reset();
        test_passthrough();
        test_delay3();
        test_saturation();
        test_wrap();
        test_reconfig();
        test_midreset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
